// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, packet-locked arbiter for a shared fifo write port
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         fifo_din,
    output logic                     fifo_wput,
    input  logic                     fifo_full,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     pkt_done,
    output logic [IDX_W-1:0]         pkt_src,
    output logic [CNT_WIDTH-1:0]     pkt_words
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]           state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 xfer;

    assign busy      = (state == GRANT);
    assign xfer      = busy & req_valid[owner] & ~fifo_full;
    assign fifo_wput = xfer;
    // Ready comes only from registered grant and fifo_full, never from req_valid.
    assign req_ready = (busy & ~fifo_full) ? grant : '0;
    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) fifo_din = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Descending scan so the candidate nearest to ptr+1 is assigned last and wins.
    always_comb begin : pick_blk
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_valid[IDX_W'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            grant     <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            cnt       <= '0;
            pkt_done  <= 1'b0;
            pkt_src   <= '0;
            pkt_words <= '0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_found) begin
                        state <= GRANT;
                        owner <= pick_idx;
                        grant <= NUM_REQ'(1) << pick_idx;
                    end
                end
                default: begin
                    if (xfer) begin
                        cnt <= cnt_inc;
                        if (req_last[owner]) begin
                            state     <= IDLE;
                            grant     <= '0;
                            ptr       <= owner;
                            pkt_done  <= 1'b1;
                            pkt_src   <= owner;
                            pkt_words <= cnt_inc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - randomized self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [W-1:0]   fifo_din;
    logic           fifo_wput, fifo_full;
    logic [N-1:0]   grant;
    logic           busy, pkt_done;
    logic [1:0]     pkt_src;
    logic [7:0]     pkt_words;

    logic [N-1:0]   sat_ready, sat_grant;
    logic [W-1:0]   sat_din;
    logic           sat_wput, sat_busy, sat_done;
    logic [1:0]     sat_src;
    logic [3:0]     sat_words;

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .fifo_din(fifo_din),
        .fifo_wput(fifo_wput), .fifo_full(fifo_full), .grant(grant), .busy(busy),
        .pkt_done(pkt_done), .pkt_src(pkt_src), .pkt_words(pkt_words)
    );

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(sat_ready), .fifo_din(sat_din),
        .fifo_wput(sat_wput), .fifo_full(fifo_full), .grant(sat_grant), .busy(sat_busy),
        .pkt_done(sat_done), .pkt_src(sat_src), .pkt_words(sat_words)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] wq[N][$];
    bit           lq[N][$];
    bit           hold_off[N];
    logic [W-1:0] fq[$];
    bit           reader_en;

    int           last_src;
    bit           prev_ok, prev_last_xfer, done_pend;
    logic [N-1:0] prev_grant, prev_valid;
    int           exp_src, exp_words, pkt_owner, pkt_cnt;
    int           done_src_q[$];
    int           done_words_q[$];
    int           done_sat_q[$];
    logic [N-1:0] s_grant, s_ready;
    bit           s_wput, s_full;
    int           idle_work;

    function automatic logic [N-1:0] rr_pick(logic [N-1:0] v, int last);
        logic [N-1:0] one;
        one = 1;
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return one << ((last + k) % N);
        end
        return '0;
    endfunction

    function automatic bit work_left();
        for (int i = 0; i < N; i++) if (wq[i].size() > 0) return 1'b1;
        return done_pend || (s_grant != '0);
    endfunction

    task automatic model_reset();
        prev_ok = 0; prev_last_xfer = 0; done_pend = 0;
        last_src = N - 1; pkt_owner = -1; pkt_cnt = 0;
        for (int i = 0; i < N; i++) begin
            wq[i].delete(); lq[i].delete(); hold_off[i] = 0;
        end
    endtask

    task automatic add_packet(int r, int n);
        for (int k = 0; k < n; k++) begin
            wq[r].push_back(W'($urandom));
            lq[r].push_back(k == n - 1);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (wq[i].size() > 0 && !hold_off[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*W +: W] = wq[i][0];
                req_last[i] = lq[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*W +: W] = W'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        fifo_full = (fq.size() >= DEPTH);
    endtask

    task automatic monitor();
        logic [N-1:0] exp_ready, exp_grant;
        logic [W-1:0] tmp;
        bit           exp_wput, last_x, done_next, lst;
        int           ew;
        s_grant = grant; s_ready = req_ready; s_wput = fifo_wput; s_full = fifo_full;
        if (grant == '0 && req_valid != '0) idle_work++;
        checks++;
        if ($countones(grant) > 1 || busy !== (grant != '0)) begin
            errors++; $display("FAIL grant_onehot grant=%b busy=%b", grant, busy);
        end
        exp_ready = (grant != '0 && !fifo_full) ? grant : '0;
        checks++;
        if (req_ready !== exp_ready) begin
            errors++; $display("FAIL req_ready got=%b exp=%b", req_ready, exp_ready);
        end
        exp_wput = ((grant & req_valid) != '0) && !fifo_full;
        checks++;
        if (fifo_wput !== exp_wput) begin
            errors++; $display("FAIL fifo_wput got=%b exp=%b full=%b", fifo_wput, exp_wput, fifo_full);
        end
        if (prev_ok) begin
            if (prev_last_xfer) exp_grant = '0;
            else if (prev_grant != '0) exp_grant = prev_grant;
            else exp_grant = rr_pick(prev_valid, last_src);
            checks++;
            if (grant !== exp_grant) begin
                errors++; $display("FAIL grant_seq got=%b exp=%b", grant, exp_grant);
            end
        end
        checks++;
        if (done_pend) begin
            ew = (exp_words > 255) ? 255 : exp_words;
            if (pkt_done !== 1'b1 || sat_done !== 1'b1 || pkt_src !== 2'(exp_src) ||
                pkt_words !== 8'(ew) || sat_words !== 4'((exp_words > 15) ? 15 : exp_words)) begin
                errors++;
                $display("FAIL pkt_done got=%b src=%0d words=%0d sat=%0d exp src=%0d words=%0d",
                         pkt_done, pkt_src, pkt_words, sat_words, exp_src, exp_words);
            end
        end else if (pkt_done !== 1'b0 || sat_done !== 1'b0) begin
            errors++; $display("FAIL pkt_done_idle got=%b exp=0", pkt_done);
        end
        if (pkt_done === 1'b1) begin
            done_src_q.push_back(int'(pkt_src));
            done_words_q.push_back(int'(pkt_words));
            done_sat_q.push_back(int'(sat_words));
        end
        last_x = 0; done_next = 0;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i] && wq[i].size() > 0) begin
                checks++;
                if (fifo_din !== wq[i][0] || (pkt_owner >= 0 && pkt_owner != i) || !fifo_wput) begin
                    errors++;
                    $display("FAIL xfer req=%0d din=%h exp=%h owner=%0d wput=%b",
                             i, fifo_din, wq[i][0], pkt_owner, fifo_wput);
                end
                if (fifo_wput) fq.push_back(fifo_din);
                pkt_owner = i; pkt_cnt++;
                tmp = wq[i].pop_front();
                lst = lq[i].pop_front();
                if (lst) begin
                    last_x = 1; done_next = 1; exp_src = i; exp_words = pkt_cnt;
                    pkt_owner = -1; pkt_cnt = 0; last_src = i;
                end
            end
        end
        done_pend = done_next;
        prev_grant = grant; prev_valid = req_valid; prev_last_xfer = last_x; prev_ok = 1;
        if (reader_en && fq.size() > 0) tmp = fq.pop_front();
    endtask

    task automatic step();
        drive();
        #1;
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_idle(int max);
        int n;
        n = 0;
        while (work_left() && n < max) begin
            step(); n++;
        end
        checks++;
        if (n >= max) begin
            errors++; $display("FAIL run_timeout cycles=%0d limit=%0d", n, max);
        end
    endtask

    task automatic drain_fifo();
        reader_en = 1;
        for (int c = 0; c < 64 && fq.size() > 0; c++) step();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_last = '0; req_data = '0; fifo_full = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== '0 || fifo_wput !== 1'b0 || grant !== '0 || busy !== 1'b0 ||
            pkt_done !== 1'b0 || pkt_src !== 2'd0 || pkt_words !== 8'd0) begin
            errors++;
            $display("FAIL reset_state ready=%b wput=%b grant=%b busy=%b done=%b src=%0d words=%0d exp all 0",
                     req_ready, fifo_wput, grant, busy, pkt_done, pkt_src, pkt_words);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [W-1:0] exp_data[3];
        exp_data = '{8'h11, 8'h22, 8'h33};
        reader_en = 0;
        done_src_q.delete(); done_words_q.delete();
        for (int k = 0; k < 3; k++) begin
            wq[1].push_back(exp_data[k]); lq[1].push_back(k == 2);
        end
        step();
        checks++;
        if (s_grant !== 4'b0000 || s_ready !== 4'b0000) begin
            errors++; $display("FAIL single_arb_cycle grant=%b ready=%b exp 0000", s_grant, s_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (s_grant !== 4'b0010 || s_wput !== 1'b1) begin
                errors++; $display("FAIL single_word%0d grant=%b wput=%b exp 0010/1", k, s_grant, s_wput);
            end
        end
        run_until_idle(20);
        checks++;
        if (fq.size() != 3 || fq[0] !== 8'h11 || fq[1] !== 8'h22 || fq[2] !== 8'h33) begin
            errors++; $display("FAIL single_fifo size=%0d exp 3 words 11 22 33", fq.size());
        end
        checks++;
        if (done_src_q.size() != 1 || done_src_q[0] != 1 || done_words_q[0] != 3) begin
            errors++; $display("FAIL single_done count=%0d exp 1 (src 1, words 3)", done_src_q.size());
        end
        drain_fifo();
    endtask

    task automatic test_all4();
        pulse_reset();
        reader_en = 1;
        done_src_q.delete();
        for (int r = 0; r < N; r++) add_packet(r, 2);
        idle_work = 0;
        run_until_idle(60);
        checks++;
        if (done_src_q.size() != 4 || done_src_q[0] != 0 || done_src_q[1] != 1 ||
            done_src_q[2] != 2 || done_src_q[3] != 3) begin
            errors++; $display("FAIL all4_order pulses=%0d exp 4 in order 0,1,2,3", done_src_q.size());
        end
        checks++;
        if (idle_work != 4) begin
            errors++; $display("FAIL all4_idle_cycles got=%0d exp=4", idle_work);
        end
    endtask

    task automatic test_bubble();
        done_src_q.delete();
        reader_en = 1;
        add_packet(1, 6);
        add_packet(2, 2);
        hold_off[2] = 1;
        for (int c = 0; c < 3; c++) step();
        hold_off[2] = 0;
        hold_off[1] = 1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (s_grant !== 4'b0010 || s_ready[2] !== 1'b0) begin
                errors++; $display("FAIL bubble_hold grant=%b ready=%b exp grant 0010 ready[2]=0", s_grant, s_ready);
            end
        end
        hold_off[1] = 0;
        run_until_idle(40);
        checks++;
        if (done_src_q.size() != 2 || done_src_q[0] != 1 || done_src_q[1] != 2) begin
            errors++; $display("FAIL bubble_order pulses=%0d exp src 1 then 2", done_src_q.size());
        end
    endtask

    task automatic test_backpressure();
        drain_fifo();
        reader_en = 0;
        done_words_q.delete(); done_sat_q.delete();
        add_packet(0, 20);
        for (int c = 0; c < 40 && fq.size() < DEPTH; c++) step();
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (s_full !== 1'b1 || s_ready !== '0 || s_wput !== 1'b0) begin
                errors++; $display("FAIL bp_stall full=%b ready=%b wput=%b exp 1/0000/0", s_full, s_ready, s_wput);
            end
        end
        checks++;
        if (fq.size() != DEPTH || wq[0].size() != 4) begin
            errors++; $display("FAIL bp_written got=%0d exp=16 left=%0d", fq.size(), wq[0].size());
        end
        reader_en = 1;
        run_until_idle(80);
        checks++;
        if (done_words_q.size() != 1 || done_words_q[0] != 20 || done_sat_q[0] != 15) begin
            errors++; $display("FAIL bp_words pulses=%0d exp words 20 sat 15", done_words_q.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < N; r++) begin
                hold_off[r] = ($urandom_range(0, 4) == 0);
                if (wq[r].size() < 6 && $urandom_range(0, 7) == 0) add_packet(r, $urandom_range(1, 6));
            end
            reader_en = ($urandom_range(0, 9) < 6);
            step();
        end
        for (int r = 0; r < N; r++) hold_off[r] = 0;
        reader_en = 1;
        run_until_idle(3000);
    endtask

    task automatic test_reset_mid();
        drain_fifo();
        add_packet(0, 1);
        run_until_idle(10);
        add_packet(0, 5);
        for (int c = 0; c < 40 && wq[0].size() > 3; c++) step();
        #2;
        checks++;
        if (busy !== 1'b1 || fifo_wput !== 1'b1) begin
            errors++; $display("FAIL mid_pre busy=%b wput=%b exp 1/1", busy, fifo_wput);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || fifo_wput !== 1'b0 || req_ready !== '0 || busy !== 1'b0 ||
            pkt_words !== 8'd0 || pkt_src !== 2'd0) begin
            errors++;
            $display("FAIL mid_async grant=%b wput=%b ready=%b busy=%b words=%0d exp all 0",
                     grant, fifo_wput, req_ready, busy, pkt_words);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        add_packet(2, 2);
        add_packet(0, 2);
        step();
        step();
        checks++;
        if (s_grant !== 4'b0001) begin
            errors++; $display("FAIL mid_priority grant=%b exp 0001", s_grant);
        end
        run_until_idle(40);
    endtask

    initial begin
        reader_en = 1;
        for (int i = 0; i < N; i++) hold_off[i] = 0;
        s_grant = '0;
        model_reset();
        test_reset();
        test_single();
        test_all4();
        test_bubble();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin, packet-locked arbiter sharing the write port of one async_fifo among NUM_REQ requesters in the write clock domain.
- Each requester presents a valid/ready/last stream. The arbiter grants one requester per packet and holds the grant until that requester's last word is written, so packets never interleave.
- Drives fifo_din/fifo_wput and obeys fifo_full. Reports per-packet word counts for statistics logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data word width; must match the fifo WIDTH.
- CNT_WIDTH, 8, width of the packet word counter; saturates at all-ones.

Ports:
- clk  input  1  write-domain clock; same clock as the fifo wclk.
- rst  input  1  asynchronous, active-high reset.
- req_data  input  NUM_REQ*WIDTH  requester words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_valid  input  NUM_REQ  per-requester word valid.
- req_last  input  NUM_REQ  per-requester last-word-of-packet flag; qualified by valid.
- req_ready  output  NUM_REQ  per-requester accept; a word transfers when valid and ready are both 1.
- fifo_din  output  WIDTH  to fifo din.
- fifo_wput  output  1  to fifo wput.
- fifo_full  input  1  from fifo full.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- busy  output  1  1 while in GRANT state.
- pkt_done  output  1  one-cycle pulse when a packet's last word is written.
- pkt_src  output  $clog2(NUM_REQ)  index of the requester that completed the packet; valid with pkt_done.
- pkt_words  output  CNT_WIDTH  word count of the completed packet, including the last word; saturating; valid with pkt_done.

Behaviour:
- Reset, asynchronous:
  - state = IDLE; grant = 0; busy = 0; pkt_done = 0; pkt_src = 0; pkt_words = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - req_ready = 0 and fifo_wput = 0 while rst is high. A packet in flight is abandoned; the fifo keeps any words already written.
- State IDLE:
  - req_ready = 0, fifo_wput = 0.
  - If any req_valid is 1, pick the first valid index searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Register the choice into grant and go to GRANT on the next edge. Arbitration latency is 1 cycle from valid to ready.
  - The word counter clears to 0.
- State GRANT, owner g:
  - Combinational outputs:
    - req_ready[g] = ~fifo_full; all other req_ready bits = 0.
    - fifo_din = req_data slice g.
    - fifo_wput = req_valid[g] & ~fifo_full.
  - Each transfer increments the word counter, saturating at 2^CNT_WIDTH-1.
  - Transfer with req_last[g] = 1:
    - next edge: state = IDLE, pointer = g, grant = 0.
    - pkt_done pulses high for 1 cycle with pkt_src = g and pkt_words = count including this word.
  - req_valid[g] low while granted: hold the grant with no timeout. Bubbles are allowed mid-packet.
  - fifo_full high: stall. Ready is 0 and no wput is issued; resume when full drops.
- Throughput: one word per clk while the owner is valid and the fifo is not full. Between packets there is 1 idle cycle (GRANT->IDLE->GRANT).
- Fairness: the requester that just completed has the lowest priority next round. A requester that holds valid continuously is served within NUM_REQ packets.
- Requests from non-owners are ignored but not lost; requesters must hold valid until ready.
- Single-word packet (valid & last on the first transfer): a legal 1-word packet with pkt_words = 1.
- fifo_wput never asserts when fifo_full = 1, so no write is dropped.
- No combinational path from req_valid to grant. Ready depends combinationally only on state and fifo_full.

Test Plan:
- Reset then single requester:
  - Stimulus: req 1 sends 3 words 0x11, 0x22, 0x33 (last on 0x33).
  - Required: grant = 0b0010 one cycle after valid; 3 consecutive wput; fifo holds 0x11, 0x22, 0x33; pkt_done with pkt_src = 1, pkt_words = 3.
- All 4 requesters valid simultaneously after reset, each with a 2-word packet:
  - Required: grant order 0, 1, 2, 3; no interleaving in the fifo; 4 pkt_done pulses; 1 idle cycle between packets.
- Fifo backpressure:
  - Stimulus: ENTRIES = 16 fifo with the reader stopped; req 0 sends a 20-word packet.
  - Required: 16 words written; full = 1; req_ready = 0 and wput = 0 while full. Start the reader: the remaining 4 words are written, pkt_words = 20.
- Mid-packet bubble:
  - Stimulus: owner drops valid for 5 cycles while req 2 is valid.
  - Required: grant stays with the owner, req_ready[2] = 0 throughout; the packet completes, then req 2 is granted.
- Counter saturation:
  - Stimulus: CNT_WIDTH = 4, 20-word packet.
  - Required: pkt_words = 15.
- Reset mid-packet:
  - Stimulus: assert rst after 2 of 5 words.
  - Required: grant = 0, wput = 0 immediately (asynchronously); after release, requester 0 has priority again.
